// File: rtl/npu_definitions.sv
// Shared encodings for the NPU vector broadcast path: request modes and
// output-control FSM states.
package npu_definitions;

    localparam int MODE_W   = 2;
    localparam int REPEAT_W = 4;

    typedef enum logic [MODE_W-1:0] {
        MODE_BCAST  = 2'd0,
        MODE_MASKED = 2'd1,
        MODE_RAMP   = 2'd2,
        MODE_RSVD   = 2'd3
    } bcast_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } bcast_state_e;

endpackage

// File: rtl/bcast_req_fifo.sv
// Request FIFO for the vector broadcast unit. Show-ahead: rd_data always
// presents the head entry; pop retires it on the clock edge.
module bcast_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage write; entries are only read once count says they are valid.
    // NOTE: the memory array is deliberately not reset -- the count already
    // marks every slot invalid, and a reset would turn RAM into flops.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); simultaneous push and
    // pop leaves the occupancy unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of block order.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vector_broadcast_unit.sv
// Vector broadcast unit: queues scalar requests and expands each into a
// LANES-wide vector (broadcast, masked or ramp), re-emitting it in_repeat
// extra times under a valid/ready handshake.
module vector_broadcast_unit
    import npu_definitions::*;
#(
    parameter int DATA_W = 16,
    parameter int LANES  = 16,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [1:0]              in_mode,
    input  logic [LANES-1:0]        in_mask,
    input  logic [3:0]              in_repeat,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [LANES-1:0]        out_lane_valid,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    mode_err
);

    localparam int REQ_W = DATA_W + MODE_W + LANES + REPEAT_W;

    bcast_state_e            state;
    logic [REPEAT_W-1:0]     rep_cnt;
    logic                    fifo_seen_q;

    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [REQ_W-1:0]        fifo_wr;
    logic [REQ_W-1:0]        fifo_rd;

    logic [DATA_W-1:0]       head_data;
    bcast_mode_e             head_mode;
    logic [LANES-1:0]        head_mask;
    logic [REPEAT_W-1:0]     head_repeat;

    logic [LANES*DATA_W-1:0] exp_data;
    logic [LANES-1:0]        exp_lane_valid;

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign fifo_wr   = {in_repeat, in_mask, in_mode, in_data};

    assign head_data   = fifo_rd[0 +: DATA_W];
    assign head_mode   = bcast_mode_e'(fifo_rd[DATA_W +: MODE_W]);
    assign head_mask   = fifo_rd[DATA_W + MODE_W +: LANES];
    assign head_repeat = fifo_rd[DATA_W + MODE_W + LANES +: REPEAT_W];

    bcast_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data (fifo_wr),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Pop decision. From IDLE the pop waits for fifo_seen_q, which lags the
    // FIFO's non-empty flag by one cycle, fixing accept-to-valid at 2 cycles.
    // In EMIT the pop is immediate so consecutive vectors have no bubble.
    always_comb begin
        // NOTE: default every always_comb output first so no path infers a latch.
        fifo_pop = 1'b0;
        case (state)
            ST_IDLE: fifo_pop = fifo_seen_q && !fifo_empty;
            ST_EMIT: fifo_pop = out_ready && (rep_cnt == '0) && !fifo_empty;
            default: fifo_pop = 1'b0;
        endcase
    end

    // Lane expansion of the FIFO head; reserved mode falls back to broadcast.
    always_comb begin
        exp_data       = '0;
        exp_lane_valid = '1;
        for (int i = 0; i < LANES; i++) begin
            case (head_mode)
                MODE_MASKED: exp_data[i*DATA_W +: DATA_W] = head_mask[i] ? head_data : '0;
                MODE_RAMP:   exp_data[i*DATA_W +: DATA_W] = head_data + DATA_W'(i);
                default:     exp_data[i*DATA_W +: DATA_W] = head_data;
            endcase
        end
        if (head_mode == MODE_MASKED) begin
            exp_lane_valid = head_mask;
        end
    end

    // Output-control FSM with registered outputs: loads a vector on pop,
    // counts down repeats on each accepted beat, returns to IDLE when drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            rep_cnt        <= '0;
            fifo_seen_q    <= 1'b0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_lane_valid <= '0;
            mode_err       <= 1'b0;
        end else begin
            fifo_seen_q <= !fifo_empty;
            if (fifo_pop) begin
                state          <= ST_EMIT;
                out_valid      <= 1'b1;
                out_data       <= exp_data;
                out_lane_valid <= exp_lane_valid;
                rep_cnt        <= head_repeat;
                if (head_mode == MODE_RSVD) begin
                    mode_err <= 1'b1;
                end
            end else if (state == ST_EMIT && out_ready) begin
                if (rep_cnt != '0) begin
                    rep_cnt <= rep_cnt - 1'b1;
                end else begin
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            end
        end
    end

endmodule

// File: doc/vector_broadcast_unit.md
VECTOR_BROADCAST_UNIT -- requirements
Module: vector_broadcast_unit

Interface
REQ-001 Parameter DATA_W, default 16: width of one scalar element and one output lane.
REQ-002 Parameter LANES, default 16: number of output lanes, range 2..64.
REQ-003 Parameter DEPTH, default 4: input FIFO depth, power of two, minimum 2.
REQ-004 The block SHALL use clock clk and reset rst_n (asynchronous, active-low).
REQ-005 Ports SHALL be, in this order:
- clk  in  1  clock
- rst_n  in  1  reset
- in_data  in  DATA_W  scalar to distribute
- in_mode  in  2  0=BCAST, 1=MASKED, 2=RAMP, 3=reserved
- in_mask  in  LANES  lane enables, used in MASKED mode
- in_repeat  in  4  extra emissions of the same vector (0..15)
- in_valid  in  1  request
- in_ready  out  1  FIFO not full
- out_data  out  LANES*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W]
- out_lane_valid  out  LANES  per-lane valid qualifier
- out_valid  out  1  vector valid
- out_ready  in  1  downstream accept
- mode_err  out  1  sticky, reserved mode seen

Function
REQ-006 A transfer SHALL occur on an input when in_valid and in_ready are both 1 at a clk edge; in_data, in_mode, in_mask and in_repeat SHALL be captured together into the FIFO.
REQ-007 in_ready SHALL be combinational !full; there SHALL be no push while full, and no push-through path.
REQ-008 Output control SHALL be an FSM with states IDLE and EMIT.
REQ-009 In IDLE with the FIFO non-empty, the block SHALL pop one entry, load the output registers, load rep_cnt with in_repeat, set out_valid and enter EMIT.
REQ-010 Latency from input acceptance (FIFO empty, FSM IDLE) to out_valid=1 SHALL be exactly 2 cycles.
REQ-011 In EMIT, out_data, out_lane_valid and out_valid SHALL hold stable while out_ready=0.
REQ-012 In EMIT, on out_valid&&out_ready with rep_cnt>0, rep_cnt SHALL decrement and the same vector SHALL re-present on the next cycle.
REQ-013 In EMIT, on out_valid&&out_ready with rep_cnt=0:
- FIFO non-empty: pop and load the next vector with no bubble cycle.
- FIFO empty: clear out_valid and return to IDLE.
REQ-014 BCAST SHALL set every lane to in_data and out_lane_valid to all ones.
REQ-015 MASKED SHALL set lane i to in_data where in_mask[i]=1 and to 0 otherwise; out_lane_valid SHALL equal in_mask.
REQ-016 MASKED with in_mask=0 SHALL still emit a vector: out_valid=1, all lanes zero.
REQ-017 RAMP SHALL set lane i to (in_data + i) mod 2^DATA_W, wrapping silently, with out_lane_valid all ones.
REQ-018 Mode 3 SHALL behave as BCAST and set mode_err at the cycle the entry is popped; mode_err SHALL clear only on reset.
REQ-019 A push and a pop in the same cycle SHALL leave the FIFO occupancy unchanged.
REQ-020 FIFO pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from a log2(DEPTH)+1-bit count.

Reset
REQ-021 Asserting rst_n, including mid-emission, SHALL immediately:
- empty the FIFO
- set the FSM to IDLE and rep_cnt to 0
- drive out_valid=0, out_data=0, out_lane_valid=0, mode_err=0
- leave in_ready=1
REQ-022 After rst_n deasserts, the first accepted input SHALL be handled per REQ-010, with no residual vector emitted.

Structure
REQ-023 Mode encodings (BCAST/MASKED/RAMP/RSVD) and FSM state encodings SHALL live in the shared npu_definitions package/header.
REQ-024 The FIFO SHALL be a separate sub-module, bcast_req_fifo, parametrised by width and DEPTH; lane expansion and the FSM SHALL stay in vector_broadcast_unit.

Verification
REQ-025 BCAST 0x1234, repeat=0, out_ready=1 -> out_valid exactly 2 cycles after accept; all 16 lanes 0x1234; lane_valid=0xFFFF; one beat only.
REQ-026 MASKED 0xABCD, mask=0x00F1 -> lanes 0,4,5,6,7 = 0xABCD, all other lanes 0; lane_valid=0x00F1.
REQ-027 RAMP 0xFFFE -> lane0=0xFFFE, lane1=0xFFFF, lane2=0x0000, lane15=0x000D.
REQ-028 BCAST 0x0007 with repeat=3, out_ready toggling 1,0,1,1,0,1 -> exactly 4 handshakes of 0x0007, values stable during stalls; then IDLE.
REQ-029 out_ready=0, push 5 entries at DEPTH=4 -> in_ready=0 after 4 FIFO entries plus 1 in the output register; release -> 5 vectors in order, back-to-back with no bubble.
REQ-030 rst_n low mid-repeat (rep_cnt=2) with 2 queued entries, mode 3 seen earlier -> all outputs 0 and mode_err=0 next sample; none of the queued vectors appear after reset.
